// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered, handshaked immediate-formation stage.
// Forms a datapath-width operand from the raw instruction immediate
// (sign/zero extend, branch offset, upper immediate) or from a stored
// prefix concatenated with the immediate.
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   in_valid/ready   request handshake from decode
//   imm_in           raw immediate field (IN_W bits)
//   mode             00 SEXT, 01 ZEXT, 10 SEXT_SHL1, 11 UPPER
//   prefix_load      request only stores prefix bits, no output
//   flush            synchronous pipeline flush
//   out_valid/ready  result handshake towards the operand mux
//   imm_out          formed immediate (OUT_W bits)
//   prefix_used      imm_out came from prefix concatenation
//   prefix_pending   a stored prefix awaits its consumer
module imm_extend_unit #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm_in,
    input  logic [1:0]       mode,
    input  logic             prefix_load,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] imm_out,
    output logic             prefix_used,
    output logic             prefix_pending
);

    // The prefix supplies exactly the bits the raw field cannot reach.
    localparam int PREFIX_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        M_SEXT  = 2'b00,
        M_ZEXT  = 2'b01,
        M_SHL1  = 2'b10,
        M_UPPER = 2'b11
    } mode_e;

    logic                r_out_valid;
    logic [OUT_W-1:0]    r_imm;
    logic                r_used;
    logic [PREFIX_W-1:0] r_prefix;
    logic                r_pending;

    mode_e               w_mode;
    logic                w_accept;
    logic                w_take;
    logic                w_pload;
    logic                w_drain;
    logic [OUT_W-1:0]    w_sext;
    logic [OUT_W-1:0]    w_zext;
    logic [OUT_W-1:0]    w_shl1;
    logic [OUT_W-1:0]    w_upper;
    logic [OUT_W-1:0]    w_cat;
    logic [OUT_W-1:0]    w_formed;

    // Handshake. Flush blocks acceptance so a squashed request
    // cannot leak into the output or the prefix register.
    assign in_ready = !flush && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_take   = w_accept && !prefix_load;
    assign w_pload  = w_accept && prefix_load;
    assign w_drain  = r_out_valid && out_ready;

    assign w_mode = mode_e'(mode);

    // Candidate results, pure bit manipulation.
    assign w_sext  = {{PREFIX_W{imm_in[IN_W-1]}}, imm_in};
    assign w_zext  = {{PREFIX_W{1'b0}}, imm_in};
    assign w_shl1  = {w_sext[OUT_W-2:0], 1'b0};
    assign w_upper = {imm_in, {PREFIX_W{1'b0}}};
    assign w_cat   = {r_prefix, imm_in};

    // A pending prefix overrides the mode entirely.
    always_comb begin
        w_formed = w_sext;
        if (r_pending) begin
            w_formed = w_cat;
        end else begin
            unique case (w_mode)
                M_SEXT:  w_formed = w_sext;
                M_ZEXT:  w_formed = w_zext;
                M_SHL1:  w_formed = w_shl1;
                M_UPPER: w_formed = w_upper;
            endcase
        end
    end

    // Output register: loads on a non-prefix accept, otherwise
    // empties when the consumer takes the current value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_imm       <= '0;
            r_used      <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_used      <= 1'b0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_imm       <= w_formed;
            r_used      <= r_pending;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_used      <= 1'b0;
        end
    end

    // Prefix register: a later load overwrites, a consume clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefix  <= '0;
            r_pending <= 1'b0;
        end else if (flush) begin
            r_pending <= 1'b0;
        end else if (w_pload) begin
            r_prefix  <= imm_in[PREFIX_W-1:0];
            r_pending <= 1'b1;
        end else if (w_take) begin
            r_pending <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign imm_out        = r_imm;
    assign prefix_used    = r_used;
    assign prefix_pending = r_pending;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed vector table plus hand-written
// sequences for backpressure, flush and asynchronous reset.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  imm_in = '0;
    logic [1:0]  mode = 2'b00;
    logic        prefix_load = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] imm_out;
    logic        prefix_used;
    logic        prefix_pending;

    int n_vec = 0;
    int n_err = 0;

    imm_extend_unit #(.IN_W(9), .OUT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imm_in(imm_in),
        .mode(mode),
        .prefix_load(prefix_load),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .imm_out(imm_out),
        .prefix_used(prefix_used),
        .prefix_pending(prefix_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pl;
        logic [1:0]  md;
        logic [8:0]  imm;
        logic        exp_valid;
        logic [15:0] exp_out;
        logic        exp_used;
        logic        exp_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic pl, input logic [1:0] m,
                        input logic [8:0] d);
        @(negedge clk);
        in_valid    = 1'b1;
        prefix_load = pl;
        mode        = m;
        imm_in      = d;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        prefix_load = 1'b0;
    endtask

    initial begin
        tbl.push_back('{"sext_1fb",  0, 2'b00, 9'h1FB, 1, 16'hFFFB, 0, 0});
        tbl.push_back('{"zext_1fb",  0, 2'b01, 9'h1FB, 1, 16'h01FB, 0, 0});
        tbl.push_back('{"shl1_1fb",  0, 2'b10, 9'h1FB, 1, 16'hFFF6, 0, 0});
        tbl.push_back('{"upper_1fb", 0, 2'b11, 9'h1FB, 1, 16'hFD80, 0, 0});
        tbl.push_back('{"sext_0ff",  0, 2'b00, 9'h0FF, 1, 16'h00FF, 0, 0});
        tbl.push_back('{"sext_100",  0, 2'b00, 9'h100, 1, 16'hFF00, 0, 0});
        tbl.push_back('{"sext_000",  0, 2'b00, 9'h000, 1, 16'h0000, 0, 0});
        tbl.push_back('{"pfx_load",  1, 2'b11, 9'h05A, 0, 16'h0000, 0, 1});
        tbl.push_back('{"pfx_cons",  0, 2'b00, 9'h0C3, 1, 16'hB4C3, 1, 0});
        tbl.push_back('{"post_pfx",  0, 2'b00, 9'h0C3, 1, 16'h00C3, 0, 0});
        tbl.push_back('{"pfx_ld_a",  1, 2'b00, 9'h07F, 0, 16'h0000, 0, 1});
        tbl.push_back('{"pfx_ld_b",  1, 2'b01, 9'h081, 0, 16'h0000, 0, 1});
        tbl.push_back('{"pfx_ovwr",  0, 2'b11, 9'h100, 1, 16'h0300, 1, 0});
        tbl.push_back('{"shl1_100",  0, 2'b10, 9'h100, 1, 16'hFE00, 0, 0});
        tbl.push_back('{"upper_001", 0, 2'b11, 9'h001, 1, 16'h0080, 0, 0});

        // Reset state.
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_imm_out", imm_out, 16'h0000);
        chk("rst_used", 16'(prefix_used), 16'h0);
        chk("rst_pending", 16'(prefix_pending), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table at full throughput.
        foreach (tbl[i]) begin
            send(tbl[i].pl, tbl[i].md, tbl[i].imm);
            chk({tbl[i].name, "_valid"}, 16'(out_valid),
                16'(tbl[i].exp_valid));
            chk({tbl[i].name, "_pend"}, 16'(prefix_pending),
                16'(tbl[i].exp_pend));
            if (tbl[i].exp_valid) begin
                chk({tbl[i].name, "_out"}, imm_out, tbl[i].exp_out);
                chk({tbl[i].name, "_used"}, 16'(prefix_used),
                    16'(tbl[i].exp_used));
            end
        end
        @(posedge clk);
        #1;
        chk("drain_valid", 16'(out_valid), 16'h0);

        // Backpressure: second request stalls behind a held result.
        out_ready = 1'b0;
        send(1'b0, 2'b00, 9'h005);
        chk("bp_first_valid", 16'(out_valid), 16'h1);
        chk("bp_first_out", imm_out, 16'h0005);
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 2'b00;
        imm_in   = 9'h1FB;
        #1;
        chk("bp_in_ready_low", 16'(in_ready), 16'h0);
        @(posedge clk);
        #1;
        chk("bp_hold_out", imm_out, 16'h0005);
        chk("bp_hold_valid", 16'(out_valid), 16'h1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_xfer_out", imm_out, 16'h0005);
        chk("bp_in_ready_high", 16'(in_ready), 16'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_valid", 16'(out_valid), 16'h1);
        chk("bp_second_out", imm_out, 16'hFFFB);
        @(posedge clk);
        #1;
        chk("bp_no_dup", 16'(out_valid), 16'h0);

        // Flush with a held result and a request presented.
        out_ready = 1'b0;
        send(1'b0, 2'b01, 9'h0AA);
        chk("fl_setup_valid", 16'(out_valid), 16'h1);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        imm_in   = 9'h011;
        #1;
        chk("fl_in_ready", 16'(in_ready), 16'h0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 16'(out_valid), 16'h0);
        out_ready = 1'b1;

        // Flush with a pending prefix and a would-be consumer presented.
        send(1'b1, 2'b00, 9'h07F);
        chk("fl_pfx_pend", 16'(prefix_pending), 16'h1);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        mode     = 2'b00;
        imm_in   = 9'h022;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_pfx_cleared", 16'(prefix_pending), 16'h0);
        chk("fl_pfx_no_out", 16'(out_valid), 16'h0);
        send(1'b0, 2'b00, 9'h022);
        chk("fl_after_out", imm_out, 16'h0022);
        chk("fl_after_used", 16'(prefix_used), 16'h0);

        // Async reset while a result is held.
        out_ready = 1'b0;
        send(1'b0, 2'b00, 9'h1FB);
        chk("ar_setup_valid", 16'(out_valid), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_clr", 16'(out_valid), 16'h0);
        chk("ar_imm_clr", imm_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Async reset while a prefix is pending.
        send(1'b1, 2'b00, 9'h07F);
        chk("ar_setup_pend", 16'(prefix_pending), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pend_clr", 16'(prefix_pending), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 2'b00, 9'h1FB);
        chk("ar_after_out", imm_out, 16'hFFFB);
        chk("ar_after_used", 16'(prefix_used), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
Parametrised immediate-formation stage for the 16-bit datapath. It replaces the fixed 9-to-16 sign extender with a handshaked, registered unit. The unit supports sign-extend, zero-extend, branch-offset (shift-left-1) and upper-immediate modes. A prefix register lets a preceding prefix instruction supply the upper bits of a full-width constant. It sits between decode and the operand mux in front of the ALU.

Parameters:
IN_W, 9, width of raw immediate field from the instruction
OUT_W, 16, datapath width; IN_W < OUT_W required
PREFIX_W, OUT_W-IN_W (7), width of stored prefix bits (derived; not overridden independently)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  immediate request valid
in_ready  output  1  unit can accept a request this cycle
imm_in  input  IN_W  raw immediate field
mode  input  2  00 SEXT, 01 ZEXT, 10 SEXT_SHL1, 11 UPPER
prefix_load  input  1  request is a prefix: store bits, produce no output
flush  input  1  synchronous pipeline flush
out_valid  output  1  imm_out valid
out_ready  input  1  consumer accepts imm_out
imm_out  output  OUT_W  formed immediate
prefix_used  output  1  qualifies imm_out: result came from prefix concatenation
prefix_pending  output  1  a stored prefix awaits use

Behaviour:
- Reset, asynchronous, rst_n=0: out_valid=0, imm_out=0, prefix_used=0, prefix register=0, prefix_pending=0. Any in-flight output or prefix is lost.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready. in_ready is forced 0 in a flush cycle.
- Output register, 1-cycle latency: an accepted non-prefix request appears on imm_out with out_valid=1 on the next edge.
- imm_out and prefix_used hold stable while out_valid && !out_ready.
- Output transfer: out_valid && out_ready. The register clears out_valid unless a new non-prefix request is accepted in the same cycle, in which case it loads directly (full throughput).
- Modes, applied when no prefix is pending:
  - SEXT: replicate imm_in[IN_W-1] into bits OUT_W-1..IN_W.
  - ZEXT: upper bits = 0.
  - SEXT_SHL1: sign-extend, shift left 1, bit0=0, truncate to OUT_W.
  - UPPER: imm_out = imm_in << PREFIX_W; low PREFIX_W bits = 0.
- Prefix load (accepted request with prefix_load=1):
  - Prefix register <= imm_in[PREFIX_W-1:0]; prefix_pending <= 1.
  - No output is generated and the output register is untouched, except that a normal out_ready drain still applies.
  - mode is ignored.
  - A second prefix_load while pending overwrites the stored bits.
- Prefix consume (accepted non-prefix request while prefix_pending=1):
  - imm_out = {prefix, imm_in}, mode ignored; prefix_used=1; prefix_pending <= 0 on the same edge.
  - Otherwise prefix_used=0.
- Flush (synchronous, highest priority after reset): next edge out_valid=0, prefix_pending=0, prefix_used=0. Any request presented that cycle is not accepted. imm_out data may hold its old value.
- in_valid with in_ready=0: no state change; the requester must hold imm_in, mode and prefix_load stable until accepted.
- Widths: all arithmetic is unsigned bit manipulation; no carry or overflow flag. The shift mode silently discards the top bit.

Test Plan:
- Mode sweep (defaults, out_ready=1), imm_in=9'h1FB, one cycle later:
  - SEXT -> 16'hFFFB
  - ZEXT -> 16'h01FB
  - SEXT_SHL1 -> 16'hFFF6
  - UPPER -> 16'hFD80
- Boundary values:
  - SEXT 9'h0FF -> 16'h00FF
  - SEXT 9'h100 -> 16'hFF00
  - SEXT 9'h000 -> 16'h0000
- Prefix pair: prefix_load with imm_in=9'h05A, then imm_in=9'h0C3 (mode=SEXT) -> imm_out=16'hB4C3, prefix_used=1, prefix_pending 1 then 0. A following SEXT 9'h0C3 -> 16'h00C3, prefix_used=0.
- Backpressure: out_ready=0, send 9'h005 then 9'h1FB:
  - first -> 16'h0005 held
  - in_ready=0, second stalled
  - raise out_ready -> 16'h0005 transfers, then 16'hFFFB next cycle
  - nothing dropped or duplicated
- Flush: with out_valid=1 and prefix_pending=1, pulse flush with in_valid=1 -> next cycle out_valid=0, prefix_pending=0, request not accepted.
- Async reset mid-operation: drop rst_n between clock edges while out_valid=1 and prefix_pending=1 -> outputs clear immediately without a clock edge. After release, SEXT 9'h1FB -> 16'hFFFB with prefix_used=0.
